// File: rtl/mac_lane_array.sv
// Multi-lane signed fixed-point dot-product engine: one multiplier stage, one accumulate stage,
// then a Q-format rescale with saturation, returned through a valid/ready handshake.
module mac_lane_array #(
    parameter int DATA_W = 16,
    parameter int FRAC_W = 8,
    parameter int LANES  = 4,
    parameter int LEN_W  = 10
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    input  logic                    start,
    input  logic [LEN_W-1:0]        len,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LANES*DATA_W-1:0] din1,
    input  logic [LANES*DATA_W-1:0] din2,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LANES*DATA_W-1:0] dout,
    output logic [LANES-1:0]        sat_flag,
    output logic                    busy
);
    localparam int ACC_W = 2 * DATA_W + LEN_W;
    localparam int PRD_W = 2 * DATA_W;
    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, ACC, DRAIN, OUT} state_t;

    state_t                    state_q, state_d;
    logic [LEN_W-1:0]          len_q, len_d;
    logic [LEN_W-1:0]          cnt_q, cnt_d;
    logic                      drain_q, drain_d;
    logic [LANES*DATA_W-1:0]   dout_q, dout_d;
    logic [LANES-1:0]          sat_q, sat_d;
    logic                      vld_p0_q, vld_p0_d;
    logic signed [PRD_W-1:0]   prod_p0_q [LANES];
    logic signed [PRD_W-1:0]   prod_p0_d [LANES];
    logic signed [ACC_W-1:0]   acc_p1_q [LANES];
    logic signed [ACC_W-1:0]   acc_p1_d [LANES];
    logic                      beat;

    // Returns {clipped, value}; the shift floors toward minus infinity.
    function automatic logic [DATA_W:0] rescale(input logic signed [ACC_W-1:0] acc);
        logic signed [ACC_W-1:0] s;
        s = acc >>> FRAC_W;
        if (s > SAT_MAX)
            rescale = {1'b1, SAT_MAX[DATA_W-1:0]};
        else if (s < SAT_MIN)
            rescale = {1'b1, SAT_MIN[DATA_W-1:0]};
        else
            rescale = {1'b0, s[DATA_W-1:0]};
    endfunction

    assign beat      = in_valid && (state_q == ACC);
    assign in_ready  = (state_q == ACC);
    assign out_valid = (state_q == OUT);
    assign busy      = (state_q != IDLE);
    assign dout      = dout_q;
    assign sat_flag  = sat_q;

    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        cnt_d    = cnt_q;
        drain_d  = drain_q;
        dout_d   = dout_q;
        sat_d    = sat_q;
        vld_p0_d = beat;
        for (int k = 0; k < LANES; k++) begin
            prod_p0_d[k] = PRD_W'($signed(din1[k*DATA_W +: DATA_W]))
                         * PRD_W'($signed(din2[k*DATA_W +: DATA_W]));
            acc_p1_d[k]  = vld_p0_q ? acc_p1_q[k] + ACC_W'(prod_p0_q[k]) : acc_p1_q[k];
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    len_d   = len;
                    cnt_d   = '0;
                    sat_d   = '0;
                    drain_d = 1'b0;
                    for (int k = 0; k < LANES; k++) acc_p1_d[k] = '0;
                    state_d = (len != '0) ? ACC : DRAIN;
                end
            end
            ACC: begin
                if (beat) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_d == len_q) state_d = DRAIN;
                end
            end
            // First DRAIN cycle lets the last product land in the accumulator; second loads the result.
            DRAIN: begin
                drain_d = 1'b1;
                if (drain_q) begin
                    for (int k = 0; k < LANES; k++)
                        {sat_d[k], dout_d[k*DATA_W +: DATA_W]} = rescale(acc_p1_q[k]);
                    drain_d = 1'b0;
                    state_d = OUT;
                end
            end
            OUT: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (clear) begin
            state_d  = IDLE;
            len_d    = '0;
            cnt_d    = '0;
            drain_d  = 1'b0;
            dout_d   = '0;
            sat_d    = '0;
            vld_p0_d = 1'b0;
            for (int k = 0; k < LANES; k++) begin
                prod_p0_d[k] = '0;
                acc_p1_d[k]  = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            len_q    <= '0;
            cnt_q    <= '0;
            drain_q  <= 1'b0;
            dout_q   <= '0;
            sat_q    <= '0;
            vld_p0_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            cnt_q    <= cnt_d;
            drain_q  <= drain_d;
            dout_q   <= dout_d;
            sat_q    <= sat_d;
            vld_p0_q <= vld_p0_d;
        end
    end

    // Datapath registers are qualified by vld_p0_q and zeroed on start, so they need no reset.
    always_ff @(posedge clk) begin
        for (int k = 0; k < LANES; k++) begin
            prod_p0_q[k] <= prod_p0_d[k];
            acc_p1_q[k]  <= acc_p1_d[k];
        end
    end
endmodule

// File: tb/tb_mac_lane_array.sv
// Directed bench for mac_lane_array: a vector table of full dot products plus hand-written
// handshake, abort and asynchronous-reset sequences.
module tb_mac_lane_array;
    logic        clk = 1'b0;
    logic        rst;
    logic        clear;
    logic        start;
    logic [9:0]  len;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] din1;
    logic [63:0] din2;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] dout;
    logic [3:0]  sat_flag;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int          len;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] exp_dout;
        logic [3:0]  exp_sat;
    } vec_t;

    vec_t vecs[6];

    mac_lane_array #(.DATA_W(16), .FRAC_W(8), .LANES(4), .LEN_W(10)) dut (
        .clk(clk), .rst(rst), .clear(clear), .start(start), .len(len),
        .in_valid(in_valid), .in_ready(in_ready), .din1(din1), .din2(din2),
        .out_valid(out_valid), .out_ready(out_ready), .dout(dout),
        .sat_flag(sat_flag), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Full run with continuous in_valid; start is accepted in the current IDLE cycle.
    task automatic run_vec(input vec_t v, input int idx);
        int n;
        len      = 10'(v.len);
        din1     = v.a;
        din2     = v.b;
        in_valid = 1'b1;
        start    = 1'b1;
        step();
        start = 1'b0;
        n = 0;
        while (!out_valid && n < 50) begin
            step();
            n++;
        end
        check($sformatf("v%0d_latency", idx), 64'(n), 64'(v.len + 2));
        check($sformatf("v%0d_dout", idx), dout, v.exp_dout);
        check($sformatf("v%0d_sat", idx), 64'(sat_flag), 64'(v.exp_sat));
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check($sformatf("v%0d_idle", idx), 64'({out_valid, busy}), 64'd0);
        check($sformatf("v%0d_hold", idx), dout, v.exp_dout);
    endtask

    initial begin
        int   n;
        logic seen;
        logic [4:0] pat;
        vec_t r;

        vecs[0] = '{3, 64'h0000_0000_0000_0100, 64'h0000_0000_0000_0200,
                    64'h0000_0000_0000_0600, 4'b0000};
        vecs[1] = '{2, 64'h0001_FE80_FF00_0000, 64'h0001_FE00_0100_0000,
                    64'h0000_0600_FE00_0000, 4'b0000};
        vecs[2] = '{4, 64'h0000_0000_7FFF_7FFF, 64'h0000_0000_8000_7FFF,
                    64'h0000_0000_8000_7FFF, 4'b0011};
        vecs[3] = '{0, 64'h0100_0100_0100_0100, 64'h0100_0100_0100_0100,
                    64'h0000_0000_0000_0000, 4'b0000};
        vecs[4] = '{1, 64'h7FFF_8000_0001_FFFF, 64'h0100_0100_0001_0001,
                    64'h7FFF_8000_0000_FFFF, 4'b0000};
        vecs[5] = '{1, 64'h0000_0000_8000_7FFF, 64'h0000_0000_0101_0101,
                    64'h0000_0000_8000_7FFF, 4'b0011};

        rst = 1'b0; clear = 1'b0; start = 1'b0; len = '0; in_valid = 1'b0;
        din1 = '0; din2 = '0; out_ready = 1'b0;
        #2;
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_dout", dout, 64'd0);
        check("rst_sat", 64'(sat_flag), 64'd0);
        step();
        #2 rst = 1'b1;
        step();

        // Table runs are issued back to back: each start lands in the first IDLE cycle.
        for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

        // Handshake: gapped in_valid, then a stalled consumer.
        pat  = 5'b11001;
        len  = 10'd3;
        din1 = 64'h0000_0000_0000_0100;
        din2 = 64'h0000_0000_0000_0200;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = pat[i];
            step();
        end
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin
            step();
            n++;
        end
        check("hs_latency", 64'(n), 64'd2);
        check("hs_dout", dout, 64'h0000_0000_0000_0600);
        start = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check($sformatf("hs_stall%0d_valid", i), 64'({out_valid, busy}), 64'd3);
            check($sformatf("hs_stall%0d_dout", i), dout, 64'h0000_0000_0000_0600);
        end
        start = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("hs_idle", 64'({out_valid, busy}), 64'd0);

        // Abort after two of five beats.
        len  = 10'd5;
        din1 = 64'h0000_0000_0000_0100;
        din2 = 64'h0000_0000_0000_0100;
        in_valid = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        clear = 1'b1;
        in_valid = 1'b0;
        step();
        clear = 1'b0;
        check("abort_state", 64'({busy, in_ready, out_valid}), 64'd0);
        check("abort_dout", dout, 64'd0);
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            seen = seen | out_valid | busy;
        end
        check("abort_quiet", 64'(seen), 64'd0);
        r = '{1, 64'h0000_0000_0000_0100, 64'h0000_0000_0000_0100,
              64'h0000_0000_0000_0100, 4'b0000};
        run_vec(r, 6);

        // Asynchronous reset while accumulating.
        len  = 10'd5;
        in_valid = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        check("areset_pre_busy", 64'({busy, in_ready}), 64'd3);
        rst = 1'b0;
        #1;
        check("areset_ctrl", 64'({busy, in_ready, out_valid}), 64'd0);
        check("areset_dout", dout, 64'd0);
        #2 rst = 1'b1;
        in_valid = 1'b0;
        step();
        check("areset_after", 64'({busy, out_valid}), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
